// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch PC owner with single-outstanding imem request, decode buffer and branch redirect
module pc_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_sel,
  input  logic [XLEN-1:0] alu_target,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            misaligned
);

  typedef enum logic [0:0] {REQ, WAIT_RSP} state_t;

  state_t          state;
  logic [XLEN-1:0] pc_q;
  logic            drop_q;

  logic            handshake;
  logic            consume;
  logic            load_rsp;
  logic [XLEN-1:0] redirect_pc;

  // A request may only go out when the decode buffer is empty or drains this
  // edge, so a returning response always finds room. Gated by rst so nothing
  // is offered to memory during the reset cycle.
  assign imem_addr      = pc_q;
  assign imem_req_valid = !rst && (state == REQ) && (!inst_valid || !stall);
  assign handshake      = imem_req_valid && imem_req_ready;
  assign consume        = inst_valid && !stall;
  // A response is only kept if it belongs to the current path: not marked for
  // dropping and not racing a redirect on the same edge.
  assign load_rsp       = (state == WAIT_RSP) && imem_rsp_valid && !drop_q && !pc_sel;
  assign redirect_pc    = {alu_target[XLEN-1:2], 2'b00};

  // Request/response sequencing, PC update, decode buffer and redirect handling
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= pc_sel && (alu_target[1:0] != 2'b00);

      case (state)
        REQ: begin
          if (handshake) begin
            state  <= WAIT_RSP;
            // Request accepted for the old PC while redirecting: squash it.
            drop_q <= pc_sel;
          end
        end
        WAIT_RSP: begin
          if (imem_rsp_valid) begin
            state  <= REQ;
            drop_q <= 1'b0;
          end else if (pc_sel) begin
            drop_q <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase

      if (pc_sel) begin
        pc_q       <= redirect_pc;
        inst_valid <= 1'b0;
      end else if (load_rsp) begin
        inst       <= imem_rsp_data;
        inst_pc    <= pc_q;
        inst_valid <= 1'b1;
        pc_q       <= pc_q + XLEN'(4);
      end else if (consume) begin
        inst_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit with random memory, stall and redirects
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        pc_sel;
  logic [31:0] alu_target;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misaligned;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_sel         (pc_sel),
    .alu_target     (alu_target),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .misaligned     (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- memory model: one outstanding request, random latency
  int          rdy_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  bit          pending = 0;
  logic [31:0] p_addr;
  int          cnt;

  initial begin
    bit          hs;
    bit          rv;
    logic [31:0] a;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready;
      a  = imem_addr;
      rv = imem_rsp_valid;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (rv) pending = 0;
      if (hs) begin
        pending = 1;
        p_addr  = a;
        cnt     = $urandom_range(lat_max, lat_min);
      end else if (pending && cnt > 0) begin
        cnt--;
      end
      if (pending && cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(p_addr);
      end
      imem_req_ready = !pending && ($urandom_range(99, 0) < rdy_pct);
    end
  end

  // ---------------- scoreboard: redirects pushed by stimulus, popped by monitor
  logic [31:0] redir_q[$];
  logic [31:0] hs_addrs[$];
  logic [31:0] exp_pc = RESET_PC;
  bit          exp_mis = 0;
  bit          was_rst = 0;
  int          n_consumed = 0;

  // Architectural view: decode sees consecutive PCs from RESET_PC, restarting at
  // the word-aligned target after every redirect; data always matches memory.
  always @(negedge clk) begin
    logic [31:0] t;
    if (rst) begin
      chk("req_valid_in_reset", 32'(imem_req_valid), 32'd0);
      was_rst = 1;
      exp_mis = 0;
      hs_addrs.delete();
    end else begin
      if (was_rst) begin
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        exp_pc = RESET_PC;
      end else begin
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
      end
      was_rst = 0;
      exp_mis = 0;
      if (inst_valid && stall)
        chk("req_while_stalled", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid && imem_req_ready)
        hs_addrs.push_back(imem_addr);
      if (pc_sel) begin
        if (redir_q.size() == 0) begin
          chk("redir_queue_empty", 32'd1, 32'd0);
        end else begin
          t       = redir_q.pop_front();
          exp_pc  = {t[31:2], 2'b00};
          exp_mis = (t[1:0] != 2'b00);
        end
      end else if (inst_valid && !stall) begin
        chk("stream_inst_pc", inst_pc, exp_pc);
        chk("stream_inst", inst, mem_data(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_consumed++;
      end
    end
  end

  task automatic redirect(input logic [31:0] t);
    pc_sel     = 1'b1;
    alu_target = t;
    redir_q.push_back(t);
    cyc(1);
    pc_sel     = 1'b0;
  endtask

  task automatic wait_hs(input string name, input logic [31:0] exp);
    int k = 0;
    while (hs_addrs.size() == 0 && k < 40) begin
      cyc(1);
      k++;
    end
    if (hs_addrs.size() == 0) chk({name, "_timeout"}, 32'd1, 32'd0);
    else chk(name, hs_addrs[0], exp);
  endtask

  task automatic wait_inst(input string name, input logic [31:0] exp_pc_v);
    int k = 0;
    while (!inst_valid && k < 40) begin
      cyc(1);
      k++;
    end
    chk({name, "_valid"}, 32'(inst_valid), 32'd1);
    chk({name, "_pc"}, inst_pc, exp_pc_v);
    chk({name, "_data"}, inst, mem_data(exp_pc_v));
  endtask

  task automatic wait_outstanding();
    int k = 0;
    cyc(1);
    #1;
    while (!(pending && !imem_rsp_valid) && k < 40) begin
      cyc(1);
      #1;
      k++;
    end
    chk("find_wait_rsp", 32'(pending && !imem_rsp_valid), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s_inst;
    logic [31:0] s_pc;
    int          k;
    int          c0;
    rst        = 1'b1;
    pc_sel     = 1'b0;
    alu_target = '0;
    stall      = 1'b0;
    cyc(2);
    rst = 1'b0;

    // sequential fetch with 1-cycle memory
    chk("post_rst_valid", 32'(inst_valid), 32'd0);
    cyc(1);
    chk("valid_after_1", 32'(inst_valid), 32'd0);
    cyc(1);
    chk("valid_after_2", 32'(inst_valid), 32'd1);
    chk("first_inst_pc", inst_pc, RESET_PC);
    cyc(6);
    chk("hs_count", 32'(hs_addrs.size() >= 4), 32'd1);
    if (hs_addrs.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("addr_seq", hs_addrs[i], RESET_PC + 32'(4 * i));
    end

    // stall holds the buffer and blocks requests
    k = 0;
    while (!inst_valid && k < 20) begin
      cyc(1);
      k++;
    end
    stall = 1'b1;
    #1;
    s_inst = inst;
    s_pc   = inst_pc;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_inst_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, s_inst);
      chk("stall_inst_pc", inst_pc, s_pc);
      cyc(1);
    end
    stall = 1'b0;
    #1;
    chk("release_req_valid", 32'(imem_req_valid), 32'd1);
    chk("release_addr", imem_addr, s_pc + 32'd4);

    // redirect while a response is pending
    lat_min = 3;
    lat_max = 3;
    wait_outstanding();
    pc_sel     = 1'b1;
    alu_target = 32'h100;
    redir_q.push_back(32'h100);
    cyc(1);
    pc_sel = 1'b0;
    hs_addrs.delete();
    wait_hs("redir_wait_addr", 32'h100);
    wait_inst("redir_wait_inst", 32'h100);

    // redirect coincident with a request handshake
    lat_min = 2;
    lat_max = 2;
    k = 0;
    cyc(1);
    #1;
    while (!(imem_req_valid && imem_req_ready) && k < 40) begin
      cyc(1);
      #1;
      k++;
    end
    chk("find_handshake", 32'(imem_req_valid && imem_req_ready), 32'd1);
    pc_sel     = 1'b1;
    alu_target = 32'h200;
    redir_q.push_back(32'h200);
    cyc(1);
    pc_sel = 1'b0;
    hs_addrs.delete();
    wait_hs("redir_hs_addr", 32'h200);
    wait_inst("redir_hs_inst", 32'h200);

    // misaligned target
    lat_min = 0;
    lat_max = 0;
    redirect(32'h203);
    hs_addrs.delete();
    chk("misaligned_pulse", 32'(misaligned), 32'd1);
    cyc(1);
    chk("misaligned_clear", 32'(misaligned), 32'd0);
    wait_hs("misaligned_addr", 32'h200);

    // PC wraps past the top of the address space
    redirect(32'hFFFF_FFFC);
    c0 = n_consumed;
    k  = 0;
    while (n_consumed < c0 + 2 && k < 40) begin
      cyc(1);
      k++;
    end
    chk("wrap_consumed", 32'(n_consumed >= c0 + 2), 32'd1);

    // reset while a response is outstanding; the late response must be ignored
    lat_min = 3;
    lat_max = 3;
    wait_outstanding();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("rst_mid_valid", 32'(inst_valid), 32'd0);
    chk("rst_mid_addr", imem_addr, RESET_PC);
    wait_hs("rst_restart_addr", RESET_PC);
    wait_inst("rst_restart_inst", RESET_PC);

    // randomized traffic
    rdy_pct = 70;
    lat_min = 0;
    lat_max = 3;
    c0 = n_consumed;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(99, 0) < 30);
      if ($urandom_range(99, 0) < 4) begin
        pc_sel = 1'b1;
        case ($urandom_range(2, 0))
          0:       alu_target = $urandom;
          1:       alu_target = 32'($urandom_range(255, 0));
          default: alu_target = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        endcase
        redir_q.push_back(alu_target);
      end else begin
        pc_sel = 1'b0;
      end
      cyc(1);
    end
    pc_sel = 1'b0;
    stall  = 1'b0;
    cyc(10);
    chk("random_progress", 32'(n_consumed - c0 > 200), 32'd1);
    chk("redir_queue_drained", 32'(redir_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Downstream consumer of the branch-decision output `pc_sel`.
- Owns the architectural fetch PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers the returned instruction for decode, with stall support.
- On `pc_sel`, redirects to the resolved branch target and squashes any wrong-path fetch in flight.

Parameters:
- XLEN, 32, width of PC and target addresses
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  reset, synchronous, active-high
- pc_sel  input  1  1 = redirect fetch to alu_target this cycle (from branch decision)
- alu_target  input  XLEN  branch/jump target address
- stall  input  1  decode cannot accept; hold buffered instruction
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  XLEN  fetch address (= pc_q)
- imem_rsp_valid  input  1  fetch data returned (never same cycle as acceptance)
- imem_rsp_data  input  32  returned instruction
- inst_valid  output  1  inst/inst_pc hold a valid instruction
- inst  output  32  buffered instruction
- inst_pc  output  XLEN  address of inst
- misaligned  output  1  one-cycle pulse: redirect target had bits [1:0] != 0

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - pc_q=RESET_PC, state=REQ, drop_q=0.
  - inst_valid=0, inst=0, inst_pc=0, misaligned=0; imem_req_valid=0 during the reset cycle.
  - Reset mid-transaction abandons the outstanding request; a late response in state REQ is ignored.
- Address and request outputs:
  - imem_addr = pc_q (combinational).
  - imem_req_valid = (state==REQ) && (!inst_valid || !stall). A request issues only if the output buffer is empty or drains this cycle.
- State REQ: handshake when imem_req_valid && imem_req_ready -> WAIT_RSP. Otherwise stay; addr/valid stay stable while not accepted.
- State WAIT_RSP, at most one request outstanding. On imem_rsp_valid:
  - drop_q=0: inst<=imem_rsp_data, inst_pc<=pc_q, inst_valid<=1, pc_q<=pc_q+4 (wraps modulo 2^XLEN), -> REQ.
  - drop_q=1: discard data, drop_q<=0, inst_valid unchanged, pc_q unchanged (already redirected), -> REQ.
- Consumption: inst_valid && !stall at a clock edge consumes the buffer. inst_valid<=0 unless a new response loads that same edge.
- Redirect (pc_sel=1) has priority over all other updates and is honoured regardless of stall:
  - pc_q <= {alu_target[XLEN-1:2],2'b00}; misaligned <= |alu_target[1:0].
  - inst_valid<=0: the buffered wrong-path instruction is flushed.
  - REQ with no handshake this cycle: stay REQ; the next request uses the new pc_q.
  - REQ with handshake this cycle: -> WAIT_RSP with drop_q<=1; the accepted old-PC request is squashed.
  - WAIT_RSP without imem_rsp_valid: drop_q<=1.
  - WAIT_RSP with imem_rsp_valid the same cycle: response discarded, drop_q<=0, -> REQ.
  - Back-to-back redirects: the last target wins; drop_q stays set until the single outstanding response returns.
- misaligned is otherwise 0. It is a pulse only; no trap state is kept here.
- Throughput: 1 instruction per 2 cycles with zero-wait memory (issue, respond). No speculative prefetch beyond one request.

Test Plan:
- Reset, then ready=1 and 1-cycle memory returning addr-based data -> imem_addr sequence 0,4,8,C. inst_pc matches each inst. inst_valid first high 2 cycles after reset release.
- inst_valid=1, stall held 5 cycles -> inst/inst_pc stable, imem_req_valid=0 throughout. Release stall -> next request at inst_pc+4 the same cycle.
- Redirect in WAIT_RSP: pc_sel=1, alu_target=0x100 while response for 0x8 pending -> 0x8 data never appears on inst. Next imem_addr=0x100, next inst_pc=0x100.
- pc_sel=1 coincident with request handshake for 0x10, target 0x200 -> response for 0x10 dropped. Following request at 0x200.
- alu_target=0x203 with pc_sel=1 -> misaligned pulses exactly 1 cycle. Next fetch address 0x200.
- Assert rst while in WAIT_RSP with inst_valid=1 -> next cycle all outputs 0. A stray imem_rsp_valid is ignored. Fetch restarts at RESET_PC.
